reg_xfer_ctrl: RTL and testbench

//   Command-driven initiator for the 8x8 register block: sequences its read port (oe/oaddr/odata)
//   and write port (we/iaddr/idata) to execute load-immediate, move, read-out and swap operations.

---
 rtl/reg_xfer_pkg.sv | 24 ++
 rtl/reg_xfer_ctrl.sv | 108 ++++++++++
 tb/tb_reg_xfer_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_xfer_pkg.sv
// Shared encodings for the register-block transfer controller: command opcodes,
// controller states and default bus widths.
package reg_xfer_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 3;

   typedef enum logic [1:0] {
      OP_LDI  = 2'd0,
      OP_MOV  = 2'd1,
      OP_RD   = 2'd2,
      OP_SWAP = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD1  = 3'd1,
      RD2  = 3'd2,
      WR1  = 3'd3,
      WR2  = 3'd4,
      RSP  = 3'd5
   } state_e;

endpackage

// File: rtl/reg_xfer_ctrl.sv
// Command-driven initiator for the 8x8 register block: sequences read/write port
// accesses for LDI, MOV, RD and SWAP. All rf_*/rsp_* outputs are Moore decodes.
module reg_xfer_ctrl
   import reg_xfer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              rf_oe,
   output logic [ADDR_W-1:0] rf_oaddr,
   input  logic [DATA_W-1:0] rf_odata,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_iaddr,
   output logic [DATA_W-1:0] rf_idata
);

   state_e            state_q, state_d;
   op_e               op_q;
   logic [ADDR_W-1:0] src_q, dst_q;
   logic [DATA_W-1:0] imm_q, tmp_a, tmp_b;
   logic              accept;

   assign cmd_ready = (state_q == IDLE);
   assign busy      = ~cmd_ready;
   assign accept    = cmd_valid & cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_LDI;
         src_q   <= '0;
         dst_q   <= '0;
         imm_q   <= '0;
         tmp_a   <= '0;
         tmp_b   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q  <= op_e'(cmd_op);
            src_q <= cmd_src;
            dst_q <= cmd_dst;
            imm_q <= cmd_imm;
         end
         // Register block read data is valid in the same cycle rf_oe is driven.
         if (state_q == RD1) tmp_a <= rf_odata;
         if (state_q == RD2) tmp_b <= rf_odata;
      end
   end

   always_comb begin
      state_d   = state_q;
      rf_oe     = 1'b0;
      rf_oaddr  = '0;
      rf_we     = 1'b0;
      rf_iaddr  = '0;
      rf_idata  = '0;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) state_d = (op_e'(cmd_op) == OP_LDI) ? WR1 : RD1;
         end
         RD1: begin
            rf_oe    = 1'b1;
            rf_oaddr = src_q;
            if (op_q == OP_RD)        state_d = RSP;
            else if (op_q == OP_SWAP) state_d = RD2;
            else                      state_d = WR1;
         end
         RD2: begin
            rf_oe    = 1'b1;
            rf_oaddr = dst_q;
            state_d  = WR1;
         end
         WR1: begin
            rf_we    = 1'b1;
            rf_iaddr = dst_q;
            rf_idata = (op_q == OP_LDI) ? imm_q : tmp_a;
            state_d  = (op_q == OP_SWAP) ? WR2 : IDLE;
         end
         WR2: begin
            rf_we    = 1'b1;
            rf_iaddr = src_q;
            rf_idata = tmp_b;
            state_d  = IDLE;
         end
         RSP: begin
            rsp_valid = 1'b1;
            rsp_data  = tmp_a;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl driving a behavioural 8x8 register block.
module tb_reg_xfer_ctrl;
   import reg_xfer_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'd0;
   logic [2:0] cmd_src = 3'd0, cmd_dst = 3'd0;
   logic [7:0] cmd_imm = 8'd0;
   logic       rsp_valid, rsp_ready = 1'b1;
   logic [7:0] rsp_data;
   logic       busy, rf_oe, rf_we;
   logic [2:0] rf_oaddr, rf_iaddr;
   logic [7:0] rf_odata, rf_idata;

   logic [7:0] regs [8];
   int nchk = 0, nerr = 0, overlap = 0;

   always #5 clk = ~clk;

   reg_xfer_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .busy(busy),
      .rf_oe(rf_oe), .rf_oaddr(rf_oaddr), .rf_odata(rf_odata),
      .rf_we(rf_we), .rf_iaddr(rf_iaddr), .rf_idata(rf_idata)
   );

   // Register block model: combinational read port, posedge write, no reset.
   assign rf_odata = rf_oe ? regs[rf_oaddr] : 8'h00;
   always @(posedge clk) if (rf_we) regs[rf_iaddr] <= rf_idata;

   always @(negedge clk) if (rf_oe && rf_we) overlap++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int exp_cyc(input logic [1:0] op);
      case (op)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 2;
         default: return 4;
      endcase
   endfunction

   // Issue one command with rsp_ready=1; report captured response and busy cycles.
   task automatic run_cmd(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                          input logic [7:0] imm, output logic [7:0] rsp, output int cyc);
      int n;
      rsp = 8'h00;
      cyc = 0;
      n   = 0;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      cmd_valid = 1'b1; cmd_op = op; cmd_src = s; cmd_dst = d; cmd_imm = imm;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!cmd_ready && n < 50) begin
         if (rsp_valid) rsp = rsp_data;
         cyc++;
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("cmd_timeout", 32'd1, 32'd0);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [2:0] src;
      logic [2:0] dst;
      logic [7:0] imm;
      logic [2:0] chk_addr;
      logic [7:0] exp_val;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [7:0] rsp, hold;
      int cyc, n;

      vecs[0]  = '{2'd0, 3'd0, 3'd1, 8'h12, 3'd1, 8'h12};  // LDI R1
      vecs[1]  = '{2'd0, 3'd0, 3'd2, 8'h34, 3'd2, 8'h34};  // LDI R2
      vecs[2]  = '{2'd0, 3'd0, 3'd5, 8'h5A, 3'd5, 8'h5A};  // LDI R5
      vecs[3]  = '{2'd2, 3'd3, 3'd0, 8'h00, 3'd0, 8'hA5};  // RD R3
      vecs[4]  = '{2'd1, 3'd3, 3'd0, 8'h00, 3'd0, 8'hA5};  // MOV R3->R0
      vecs[5]  = '{2'd3, 3'd1, 3'd2, 8'h00, 3'd1, 8'h34};  // SWAP 1,2
      vecs[6]  = '{2'd2, 3'd2, 3'd0, 8'h00, 3'd0, 8'h12};  // RD R2 after swap
      vecs[7]  = '{2'd3, 3'd5, 3'd5, 8'h00, 3'd5, 8'h5A};  // SWAP 5,5
      vecs[8]  = '{2'd0, 3'd0, 3'd4, 8'h77, 3'd4, 8'h77};  // LDI R4
      vecs[9]  = '{2'd1, 3'd4, 3'd4, 8'h00, 3'd4, 8'h77};  // MOV 4->4
      vecs[10] = '{2'd0, 3'd0, 3'd7, 8'hFF, 3'd7, 8'hFF};  // LDI all-ones
      vecs[11] = '{2'd2, 3'd7, 3'd0, 8'h00, 3'd0, 8'hFF};  // RD R7

      // Reset state
      #12;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_oe", rf_oe, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rf_addr", {rf_oaddr, rf_iaddr}, 0);
      chk("rst_rf_idata", rf_idata, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // LDI dst=3 imm=A5: write presented one cycle after accept
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dst = 3'd3; cmd_imm = 8'hA5;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("ldi_we", rf_we, 1);
      chk("ldi_iaddr", rf_iaddr, 3);
      chk("ldi_idata", rf_idata, 8'hA5);
      chk("ldi_oe", rf_oe, 0);
      @(negedge clk);
      chk("ldi_idle", cmd_ready, 1);
      chk("ldi_r3", regs[3], 8'hA5);
      chk("idle_idata", rf_idata, 0);

      // Table-driven command vectors
      for (int i = 0; i < 12; i++) begin
         run_cmd(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].imm, rsp, cyc);
         chk($sformatf("vec%0d_cycles", i), cyc, exp_cyc(vecs[i].op));
         if (vecs[i].op == 2'd2) chk($sformatf("vec%0d_rsp", i), rsp, vecs[i].exp_val);
         else chk($sformatf("vec%0d_reg", i), regs[vecs[i].chk_addr], vecs[i].exp_val);
      end
      chk("swap_r2", regs[2], 8'h12);

      // RD with back-pressure: response held, other commands ignored
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_src = 3'd0; rsp_ready = 1'b0;
      @(negedge clk);
      cmd_op = 2'd0; cmd_dst = 3'd0; cmd_imm = 8'hEE;  // junk LDI must not be taken
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      hold = rsp_data;
      chk("bp_rsp_data", hold, 8'hA5);
      n = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_data != hold || cmd_ready || rf_we) n++;
      end
      chk("bp_stable", n, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("bp_done", cmd_ready, 1);
      chk("bp_rsp_drop", rsp_valid, 0);
      @(negedge clk);
      chk("bp_r0_untouched", regs[0], 8'hA5);
      chk("bp_no_accept", busy, 0);

      // Reset while a response is pending: discarded immediately
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_src = 3'd1; rsp_ready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("rsp_pend", rsp_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1; rsp_ready = 1'b1;

      // Reset after SWAP 1,2 commits WR1: dst updated, src unchanged
      run_cmd(2'd0, 3'd0, 3'd1, 8'h12, rsp, cyc);
      run_cmd(2'd0, 3'd0, 3'd2, 8'h34, rsp, cyc);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd3; cmd_src = 3'd1; cmd_dst = 3'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("swap_wr1_we", rf_we, 1);
      chk("swap_wr1_iaddr", rf_iaddr, 2);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("swap_rst_we", rf_we, 0);
      chk("swap_rst_oe", rf_oe, 0);
      chk("swap_rst_ready", cmd_ready, 1);
      n = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (rf_we) n++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("swap_rst_no_we", n, 0);
      chk("swap_rst_r2", regs[2], 8'h12);
      chk("swap_rst_r1", regs[1], 8'h12);
      chk("swap_rst_idle", busy, 0);

      chk("oe_we_exclusive", overlap, 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
